// File: rtl/spmv_pkg.sv
// Shared SpMV definitions: default channel/length geometry and the CISR encoder
// state encoding. Imported by the encoder, its interface and any decoder side.
package spmv_pkg;

  localparam int unsigned CHAN_NUM_DEF = 16;
  localparam int unsigned LEN_W_DEF    = 32;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFill    = 3'd1,
    StAdvance = 3'd2,
    StDrain   = 3'd3,
    StDone    = 3'd4
  } cisr_state_e;

endpackage

// File: rtl/cisr_encoder_if.sv
// Row-length stream and per-channel FIFO write port of the CISR encoder.
//   row_len_in/valid/last/ready : CSR row lengths in row order (valid/ready handshake)
//   chan_len_out                : registered length, shared by all channel FIFOs
//   chan_push                   : one-hot write strobe into the channel FIFOs
//   chan_full                   : per-channel FIFO full
// master = row source + FIFO side, slave = encoder.
interface cisr_encoder_if #(
  parameter int unsigned CHAN_NUM = spmv_pkg::CHAN_NUM_DEF,
  parameter int unsigned LEN_W    = spmv_pkg::LEN_W_DEF
);

  logic [LEN_W-1:0]    row_len_in;
  logic                row_len_valid;
  logic                row_len_last;
  logic                row_len_ready;
  logic [LEN_W-1:0]    chan_len_out;
  logic [CHAN_NUM-1:0] chan_push;
  logic [CHAN_NUM-1:0] chan_full;

  modport master (
    output row_len_in, row_len_valid, row_len_last, chan_full,
    input  row_len_ready, chan_len_out, chan_push
  );

  modport slave (
    input  row_len_in, row_len_valid, row_len_last, chan_full,
    output row_len_ready, chan_len_out, chan_push
  );

endinterface

// File: rtl/cisr_free_sel.sv
// Lowest-index free channel picker.
//   free_mask : one bit per channel, 1 = channel free
//   sel       : index of the lowest set bit (0 when none)
//   any_free  : at least one channel is free
module cisr_free_sel #(
  parameter int unsigned CHAN_NUM = 16,
  parameter int unsigned SEL_W    = (CHAN_NUM > 1) ? $clog2(CHAN_NUM) : 1
) (
  input  logic [CHAN_NUM-1:0] free_mask,
  output logic [SEL_W-1:0]    sel,
  output logic                any_free
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    sel      = '0;
    any_free = 1'b0;
    for (int i = CHAN_NUM - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        sel      = SEL_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cisr_encoder.sv
// CISR row-length encoder: assigns CSR rows to channel slots in the order a
// decoder pops them, tracking per-channel remaining beats.
//   clk, rst_n  : clock, asynchronous active-low reset
//   spmv_init   : start/restart pulse (clears counts and beat_count, enters FILL)
//   bus         : row-length stream in, channel FIFO push out (see cisr_encoder_if)
//   busy        : not idle
//   done        : one-cycle completion pulse
//   beat_count  : beats issued since the last spmv_init (wraps)
module cisr_encoder
  import spmv_pkg::*;
#(
  parameter int unsigned CHAN_NUM = CHAN_NUM_DEF,
  parameter int unsigned LEN_W    = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                spmv_init,
  cisr_encoder_if.slave       bus,
  output logic                busy,
  output logic                done,
  output logic [31:0]         beat_count
);

  localparam int unsigned SEL_W = (CHAN_NUM > 1) ? $clog2(CHAN_NUM) : 1;

  cisr_state_e         state_q, state_d;
  logic [LEN_W-1:0]    count_q [CHAN_NUM];
  logic [LEN_W-1:0]    count_d [CHAN_NUM];
  logic [31:0]         beat_q, beat_d;
  logic [CHAN_NUM-1:0] push_q, push_d;
  logic [LEN_W-1:0]    len_q, len_d;

  logic [CHAN_NUM-1:0] free_mask;
  logic [CHAN_NUM-1:0] sel_onehot;
  logic [CHAN_NUM-1:0] free_after;
  logic [SEL_W-1:0]    sel;
  logic                any_free;
  logic                any_busy;
  logic                accept;

  always_comb begin
    for (int i = 0; i < CHAN_NUM; i++) begin
      free_mask[i] = (count_q[i] == '0);
    end
  end

  assign any_busy = ~&free_mask;

  cisr_free_sel #(
    .CHAN_NUM (CHAN_NUM),
    .SEL_W    (SEL_W)
  ) u_free_sel (
    .free_mask (free_mask),
    .sel       (sel),
    .any_free  (any_free)
  );

  assign sel_onehot        = any_free ? (CHAN_NUM'(1) << sel) : '0;
  assign bus.row_len_ready = (state_q == StFill) && any_free && !bus.chan_full[sel];
  assign accept            = bus.row_len_ready && bus.row_len_valid;
  // Free slots left once this cycle's row (if any) has claimed its channel.
  assign free_after        = free_mask & ~(accept ? sel_onehot : '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    beat_d  = beat_q;
    push_d  = '0;
    len_d   = len_q;

    if (spmv_init) begin
      state_d = StFill;
      beat_d  = '0;
      for (int i = 0; i < CHAN_NUM; i++) begin
        count_d[i] = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StFill: begin
          if (accept) begin
            // An empty row still occupies one beat in its channel.
            count_d[sel] = (bus.row_len_in == '0) ? LEN_W'(1) : bus.row_len_in;
            push_d       = sel_onehot;
            len_d        = bus.row_len_in;
          end
          if (accept && bus.row_len_last) begin
            state_d = StDrain;
          end else if (free_after == '0) begin
            state_d = StAdvance;
          end
        end
        StAdvance: begin
          for (int i = 0; i < CHAN_NUM; i++) begin
            if (count_q[i] != '0) count_d[i] = count_q[i] - LEN_W'(1);
          end
          beat_d  = beat_q + 32'd1;
          state_d = StFill;
        end
        StDrain: begin
          if (any_busy) begin
            for (int i = 0; i < CHAN_NUM; i++) begin
              if (count_q[i] != '0) count_d[i] = count_q[i] - LEN_W'(1);
            end
            beat_d = beat_q + 32'd1;
          end else begin
            state_d = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      push_q  <= '0;
      len_q   <= '0;
      for (int i = 0; i < CHAN_NUM; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      push_q  <= push_d;
      len_q   <= len_d;
      for (int i = 0; i < CHAN_NUM; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

  assign bus.chan_push    = push_q;
  assign bus.chan_len_out = len_q;
  assign busy             = (state_q != StIdle);
  assign done             = (state_q == StDone);
  assign beat_count       = beat_q;

endmodule

// File: tb/tb_cisr_encoder.sv
// Self-checking bench for cisr_encoder (CHAN_NUM=4): directed matrices,
// backpressure, restart, asynchronous reset and randomized matrices checked
// against a slot-scheduling reference model.
module tb_cisr_encoder;

  localparam int unsigned CN = 4;
  localparam int unsigned LW = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spmv_init;
  logic        busy;
  logic        done;
  logic [31:0] beat_count;

  cisr_encoder_if #(.CHAN_NUM(CN), .LEN_W(LW)) bus ();

  cisr_encoder #(
    .CHAN_NUM (CN),
    .LEN_W    (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spmv_init  (spmv_init),
    .bus        (bus.slave),
    .busy       (busy),
    .done       (done),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int unsigned rows_q[$];
  int unsigned exp_ch[$];
  int unsigned exp_beats;

  logic          drv_valid, drv_last, drv_init;
  logic [LW-1:0] drv_len;
  logic [CN-1:0] drv_full;
  bit            pend;
  logic [LW-1:0] pend_len;
  int            push_idx, row_idx, done_cnt;

  // Reference: place each row in the lowest free slot, letting time advance
  // one beat whenever all slots are occupied; the tail drains the longest slot.
  function automatic void build_model(input bit finish);
    int unsigned cnt[CN];
    int unsigned mx;
    int ch;
    exp_ch.delete();
    exp_beats = 0;
    for (int i = 0; i < CN; i++) cnt[i] = 0;
    foreach (rows_q[k]) begin
      ch = -1;
      while (ch < 0) begin
        for (int i = 0; i < CN; i++) begin
          if (ch < 0 && cnt[i] == 0) ch = i;
        end
        if (ch < 0) begin
          for (int i = 0; i < CN; i++) if (cnt[i] > 0) cnt[i]--;
          exp_beats++;
        end
      end
      cnt[ch] = (rows_q[k] == 0) ? 1 : rows_q[k];
      exp_ch.push_back(ch);
    end
    if (finish) begin
      mx = 0;
      for (int i = 0; i < CN; i++) if (cnt[i] > mx) mx = cnt[i];
      exp_beats += mx;
    end
  endfunction

  function automatic int oh_index(input logic [CN-1:0] v);
    int r = -1;
    for (int i = CN - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // One clock: check outputs of the last edge, then drive the next inputs.
  task automatic tick();
    @(negedge clk);
    if (pend) begin
      check("push_onehot", 64'($onehot(bus.chan_push)), 64'd1);
      check("push_len", bus.chan_len_out, pend_len);
      if (push_idx < exp_ch.size()) check("push_chan", oh_index(bus.chan_push), exp_ch[push_idx]);
      else check("push_extra", push_idx, exp_ch.size());
      push_idx++;
    end else begin
      check("no_push", bus.chan_push, '0);
    end
    if (done) done_cnt++;
    spmv_init         = drv_init;
    bus.row_len_valid = drv_valid;
    bus.row_len_in    = drv_len;
    bus.row_len_last  = drv_last;
    bus.chan_full     = drv_full;
    #1;
    pend     = bus.row_len_valid && bus.row_len_ready && !spmv_init;
    pend_len = bus.row_len_in;
    if (pend) row_idx++;
  endtask

  task automatic run_matrix(input int full_pct, input int hold0, input bit finish,
                            input int abort_after);
    int  cyc;
    int  extra;
    int  hold_left;
    bit  hold_now;
    build_model(finish);
    push_idx  = 0;
    row_idx   = 0;
    done_cnt  = 0;
    hold_left = hold0;
    drv_init  = 1'b1;
    drv_valid = 1'b0;
    drv_last  = 1'b0;
    drv_len   = '0;
    drv_full  = '0;
    tick();
    drv_init = 1'b0;
    tick();
    check("init_beat", beat_count, 0);
    check("init_busy", busy, 1);
    extra = -1;
    cyc   = 0;
    while (cyc < 3000) begin
      hold_now = (hold_left > 0) && (row_idx == 0);
      if (row_idx < rows_q.size()) begin
        drv_valid = hold_now || ($urandom_range(0, 3) != 0);
        drv_len   = rows_q[row_idx];
        drv_last  = finish && (row_idx == rows_q.size() - 1);
      end else begin
        drv_valid = 1'b0;
        drv_last  = 1'b0;
      end
      if (hold_now) begin
        drv_full = CN'(1);
        hold_left--;
      end else begin
        for (int i = 0; i < CN; i++) drv_full[i] = (int'($urandom_range(0, 99)) < full_pct);
      end
      tick();
      if (hold_now) check("bp_ready", bus.row_len_ready, 0);
      cyc++;
      if (extra > 0) begin
        extra--;
        if (extra == 0) break;
      end else if (extra < 0) begin
        if (abort_after > 0) begin
          if (row_idx == rows_q.size() && !pend) extra = abort_after;
        end else if (finish) begin
          if (done_cnt > 0) extra = 2;
        end else if (row_idx == rows_q.size() && !pend) begin
          break;
        end
      end
    end
    drv_valid = 1'b0;
    drv_full  = '0;
    check("rows_taken", row_idx, rows_q.size());
    check("push_count", push_idx, exp_ch.size());
    if (finish && abort_after == 0) begin
      check("beats", beat_count, exp_beats);
      check("done_once", done_cnt, 1);
      check("end_busy", busy, 0);
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    spmv_init         = 1'b0;
    bus.row_len_valid = 1'b1;
    bus.row_len_in    = 32'd5;
    bus.row_len_last  = 1'b0;
    bus.chan_full     = '0;
    drv_init  = 1'b0;
    drv_valid = 1'b1;
    drv_len   = 32'd5;
    drv_last  = 1'b0;
    drv_full  = '0;
    pend      = 1'b0;
    push_idx  = 0;
    row_idx   = 0;
    done_cnt  = 0;
    exp_ch.delete();
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_push", bus.chan_push, 0);
    check("rst_len", bus.chan_len_out, 0);
    check("rst_beat", beat_count, 0);
    check("rst_ready", bus.row_len_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: valid held high, nothing may be taken.
    tick();
    check("idle_ready", bus.row_len_ready, 0);
    tick();
    check("idle_busy", busy, 0);
    drv_valid = 1'b0;

    rows_q = '{2, 1, 3, 2, 1, 1};
    run_matrix(0, 0, 1'b1, 0);
    check("ex1_beats", beat_count, 3);

    rows_q = '{0, 0};
    run_matrix(0, 0, 1'b1, 0);
    check("ex2_beats", beat_count, 1);

    // Backpressure on channel 0 while the first row waits.
    rows_q = '{3, 1, 2};
    run_matrix(0, 4, 1'b1, 0);

    // Restart mid-FILL after three rows; model assumes empty slots afterwards.
    rows_q = '{5, 6, 7};
    run_matrix(0, 0, 1'b0, 0);
    rows_q = '{1, 4, 2, 2, 3};
    run_matrix(0, 0, 1'b1, 0);

    repeat (8) begin
      int n;
      n = int'($urandom_range(1, 12));
      rows_q.delete();
      repeat (n) rows_q.push_back($urandom_range(0, 6));
      run_matrix(int'($urandom_range(0, 40)), 0, 1'b1, 0);
    end

    // Asynchronous reset in the middle of DRAIN, away from any clock edge.
    rows_q = '{20, 20};
    run_matrix(0, 0, 1'b1, 4);
    check("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_push", bus.chan_push, 0);
    check("arst_len", bus.chan_len_out, 0);
    check("arst_beat", beat_count, 0);
    check("arst_ready", bus.row_len_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cisr_encoder.md
CISR_ENCODER -- requirements
Module: cisr_encoder

Interface
REQ-001 SHALL have parameter CHAN_NUM, default 16: number of channel slots.
REQ-002 SHALL have parameter LEN_W, default 32: row-length width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port spmv_init  input  1  start/restart pulse.
REQ-006 SHALL have port row_len_in  input  LEN_W  length of the next row, in CSR row order.
REQ-007 SHALL have port row_len_valid  input  1  row_len_in is valid.
REQ-008 SHALL have port row_len_last  input  1  the current row is the matrix's final row.
REQ-009 SHALL have port row_len_ready  output  1  row accepted when valid&&ready.
REQ-010 SHALL have port chan_len_out  output  LEN_W  registered length, shared by all channels.
REQ-011 SHALL have port chan_push  output  CHAN_NUM  one-hot write strobe into the per-channel row-length FIFOs.
REQ-012 SHALL have port chan_full  input  CHAN_NUM  per-channel FIFO full.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port beat_count  output  32  number of beats issued since the last spmv_init.

Function
REQ-016 SHALL implement states IDLE, FILL, ADVANCE, DRAIN, DONE.
REQ-017 SHALL keep a LEN_W remaining-count per channel; a channel is free when its count is 0.
REQ-018 SHALL, in FILL, select the lowest-index free channel (sel), so row order matches decoder pop priority.
REQ-019 SHALL drive row_len_ready = (state==FILL) && (free mask != 0) && !chan_full[sel], combinationally.
REQ-020 SHALL, on accept, load count[sel] with row_len_in, or with 1 when row_len_in==0 (a zero-length row occupies one beat).
REQ-021 SHALL, one cycle after accept, pulse chan_push[sel] and drive chan_len_out = the unmodified row_len_in; latency is 1; at most one push per cycle.
REQ-022 SHALL go FILL->DRAIN on accepting a row with row_len_last=1; this takes priority over REQ-023.
REQ-023 SHALL otherwise go FILL->ADVANCE when the free mask after the current cycle's load is 0.
REQ-024 SHALL, in ADVANCE (one cycle), decrement every nonzero count, increment beat_count, and return to FILL.
REQ-025 SHALL, in DRAIN, decrement every nonzero count and increment beat_count each cycle while any count is nonzero; when all counts are 0, go to DONE.
REQ-026 SHALL, in DONE, assert done for one cycle and go to IDLE; beat_count holds until the next spmv_init.
REQ-027 SHALL, on spmv_init in any state, zero all counts and beat_count, drop any pending push, and enter FILL.
REQ-028 SHALL hold state, counts and outputs when chan_full[sel] stalls FILL.
REQ-029 SHALL never let counts underflow (they saturate at 0) and SHALL let beat_count wrap modulo 2^32.

Reset
REQ-030 SHALL, while rst_n=0, immediately force state=IDLE, all counts 0, beat_count 0, chan_push 0, chan_len_out 0, done 0 and busy 0, including mid-operation.
REQ-031 SHALL, as a consequence of REQ-019 in IDLE, hold row_len_ready=0 after reset until spmv_init.

Structure
REQ-032 SHALL take the state enum and the default CHAN_NUM/LEN_W constants from the shared package spmv_pkg.
REQ-033 SHALL place lowest-free-channel selection in one sub-module, cisr_free_sel (CHAN_NUM-bit mask in, index and any-free out).

Verification
REQ-034 SHALL cover, with CHAN_NUM=4: rows {2,1,3,2,1,1}, last on the 6th -> pushes ch0{2,1}, ch1{1,1}, ch2{3}, ch3{2}; beat_count=3; done pulses once.
REQ-035 SHALL cover, with CHAN_NUM=4: rows {0,0}, last on the 2nd -> pushes ch0{0}, ch1{0}; DRAIN lasts one beat; beat_count=1.
REQ-036 SHALL cover backpressure: chan_full[0]=1 while the first row is valid -> row_len_ready=0 and no push; release -> the push goes to ch0 one cycle after accept.
REQ-037 SHALL cover asynchronous reset: rst_n low mid-DRAIN -> all outputs 0 immediately, with no clock edge.
REQ-038 SHALL cover restart: spmv_init mid-FILL after 3 rows -> counts cleared and the next row is pushed to ch0.
